pkt_fifo_writer: RTL and testbench
==================================

PKT_FIFO_WRITER -- requirements
Module: pkt_fifo_writer

Interface
REQ-001 Parameter DWIDTH, default 32: data word width; SHALL equal the downstream FIFO's DWIDTH.
REQ-002 Parameter AWIDTH, default 4: downstream FIFO address width; FIFO depth is 2**AWIDTH.
REQ-003 Parameter MAX_PKT_LEN, default 16: maximum accepted words per packet, range 1..2**AWIDTH.
REQ-004 Port clk_i  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port arst_ni  in  1  reset, asynchronous, active-low.
REQ-006 Port snk_data_i  in  DWIDTH  Avalon-ST sink data.
REQ-007 Port snk_startofpacket_i  in  1  first word of a packet.
REQ-008 Port snk_endofpacket_i  in  1  last word of a packet.
REQ-009 Port snk_valid_i  in  1  sink word valid.
REQ-010 Port snk_ready_o  out  1  sink ready; a word is accepted when snk_valid_i && snk_ready_o.
REQ-011 Port fifo_data_o  out  DWIDTH  write data to FIFO.
REQ-012 Port fifo_wrreq_o  out  1  FIFO write request.
REQ-013 Port fifo_usedw_i  in  AWIDTH+1  FIFO fill level.
REQ-014 Port pkt_len_o  out  AWIDTH+1  word count of last completed packet.
REQ-015 Port pkt_len_valid_o  out  1  one-cycle strobe qualifying pkt_len_o.
REQ-016 Port pkt_err_o  out  1  one-cycle strobe flagging a protocol/length error.

Function
REQ-017 FSM states SHALL be IDLE, RECV, DROP.
REQ-018 fifo_data_o, fifo_wrreq_o, pkt_len_o, pkt_len_valid_o, pkt_err_o SHALL be registered; a write is presented exactly 1 cycle after the accepting beat.
REQ-019 In IDLE/RECV, snk_ready_o SHALL be 1 iff fifo_usedw_i + fifo_wrreq_o < 2**AWIDTH (in-flight write counted; computed at AWIDTH+2 bits, no overflow).
REQ-020 In DROP, snk_ready_o SHALL be 1 unconditionally; no FIFO writes occur.
REQ-021 IDLE: accepted beat with sop SHALL be written, set count to 1, go to RECV; if eop also set, SHALL complete a 1-word packet and stay in IDLE.
REQ-022 IDLE: accepted beat without sop SHALL be discarded (no write) and pulse pkt_err_o; state stays IDLE.
REQ-023 RECV: accepted beat without sop SHALL be written and count incremented.
REQ-024 RECV: accepted beat with sop SHALL pulse pkt_err_o, drop the unfinished packet's length report, and restart as a new packet with count 1 (word written).
REQ-025 Packet completion (eop on a written word): pkt_len_o SHALL take the final count and pkt_len_valid_o pulse in the same cycle as the final fifo_wrreq_o; FSM returns to IDLE.
REQ-026 RECV with count == MAX_PKT_LEN and accepted beat without eop: word SHALL be discarded, pkt_err_o pulsed, FSM to DROP, no length report for that packet.
REQ-027 DROP: beats discarded until an accepted eop, then IDLE; a sop in DROP SHALL be discarded, not start a packet.
REQ-028 No accept cycles (valid low or ready low) SHALL leave state, count and strobes unchanged/low.
REQ-029 Count SHALL never exceed MAX_PKT_LEN; counter width AWIDTH+1.

Reset
REQ-030 On arst_ni low, asynchronously: state IDLE, count 0, fifo_wrreq_o 0, fifo_data_o 0, pkt_len_o 0, pkt_len_valid_o 0, pkt_err_o 0; snk_ready_o follows REQ-019 with wrreq 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet with no length or error strobe; first beat after deassertion is treated per IDLE rules.

Verification
REQ-032 Bench SHALL cover: 4-word packet (sop..eop), usedw 0 -> 4 writes, pkt_len_o=4 with pkt_len_valid_o once, no pkt_err_o.
REQ-033 Bench SHALL cover: single beat sop+eop -> 1 write, pkt_len_o=1, state IDLE.
REQ-034 Bench SHALL cover: AWIDTH=4, fifo_usedw_i=15 with write in flight -> snk_ready_o=0 until usedw drops to 14 with no write pending.
REQ-035 Bench SHALL cover: MAX_PKT_LEN=16, 20-word packet -> 16 writes, pkt_err_o once on word 17, no pkt_len_valid_o, IDLE after eop.
REQ-036 Bench SHALL cover: sop at word 3 of open packet then 2 words+eop -> pkt_err_o once, pkt_len_o=3.
REQ-037 Bench SHALL cover: arst_ni pulsed low after 2 words of a packet -> all outputs 0, next non-sop beat discarded with pkt_err_o.

Source files
------------

// File: rtl/pkt_fifo_writer.sv
// Avalon-ST sink to FIFO write-port adapter: frames packets, reports each
// completed packet's word count and flags protocol/length errors.
module pkt_fifo_writer #(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 4,
    parameter int MAX_PKT_LEN = 16
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic [DWIDTH-1:0] snk_data_i,
    input  logic              snk_startofpacket_i,
    input  logic              snk_endofpacket_i,
    input  logic              snk_valid_i,
    output logic              snk_ready_o,
    output logic [DWIDTH-1:0] fifo_data_o,
    output logic              fifo_wrreq_o,
    input  logic [AWIDTH:0]   fifo_usedw_i,
    output logic [AWIDTH:0]   pkt_len_o,
    output logic              pkt_len_valid_o,
    output logic              pkt_err_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [AWIDTH+1:0] DEPTH   = (AWIDTH+2)'(2**AWIDTH);
    localparam logic [AWIDTH:0]   MAX_LEN = (AWIDTH+1)'(MAX_PKT_LEN);
    localparam logic [AWIDTH:0]   ONE     = (AWIDTH+1)'(1);

    logic [1:0]        state_q, state_d;
    logic [AWIDTH:0]   cnt_q, cnt_d;
    logic [AWIDTH:0]   len_d;
    logic [AWIDTH+1:0] fill;
    logic              accept;
    logic              wr_d;
    logic              done_d;
    logic              err_d;

    // The registered write still in flight is not yet visible in usedw.
    assign fill        = {1'b0, fifo_usedw_i} + {{(AWIDTH+1){1'b0}}, fifo_wrreq_o};
    assign snk_ready_o = (state_q == DROP) || (fill < DEPTH);
    assign accept      = snk_valid_i && snk_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = '0;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (accept) begin
            if (state_q == DROP) begin
                if (snk_endofpacket_i) state_d = IDLE;
            end else if (snk_startofpacket_i) begin
                // A sop inside an open packet abandons it and restarts.
                err_d   = (state_q == RECV);
                wr_d    = 1'b1;
                cnt_d   = ONE;
                done_d  = snk_endofpacket_i;
                len_d   = ONE;
                state_d = snk_endofpacket_i ? IDLE : RECV;
            end else if (state_q == IDLE) begin
                err_d = 1'b1;
            end else if (cnt_q >= MAX_LEN) begin
                // Oversized packet: discard the rest up to its eop.
                err_d   = 1'b1;
                state_d = snk_endofpacket_i ? IDLE : DROP;
            end else begin
                wr_d    = 1'b1;
                cnt_d   = cnt_q + ONE;
                done_d  = snk_endofpacket_i;
                len_d   = cnt_q + ONE;
                if (snk_endofpacket_i) state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            fifo_wrreq_o    <= 1'b0;
            fifo_data_o     <= '0;
            pkt_len_o       <= '0;
            pkt_len_valid_o <= 1'b0;
            pkt_err_o       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            fifo_wrreq_o    <= wr_d;
            pkt_len_valid_o <= done_d;
            pkt_err_o       <= err_d;
            if (wr_d)   fifo_data_o <= snk_data_i;
            if (done_d) pkt_len_o   <= len_d;
        end
    end

endmodule

// File: tb/tb_pkt_fifo_writer.sv
// Directed bench for pkt_fifo_writer with default parameters
// (DWIDTH=32, AWIDTH=4, MAX_PKT_LEN=16).
module tb_pkt_fifo_writer;

    logic        clk = 1'b0;
    logic        arst_ni;
    logic [31:0] snk_data;
    logic        snk_sop, snk_eop, snk_valid, snk_ready;
    logic [31:0] fifo_data;
    logic        fifo_wrreq;
    logic [4:0]  fifo_usedw;
    logic [4:0]  pkt_len;
    logic        pkt_len_valid, pkt_err;

    int errors = 0;
    int checks = 0;

    // Monitor tallies, sampled on the falling edge.
    int wr_cnt = 0, lv_cnt = 0, err_cnt = 0, lvwr_cnt = 0;
    logic [31:0] wlog [0:63];
    int b_wr, b_lv, b_err, b_lvwr;

    always #5 clk = ~clk;

    pkt_fifo_writer dut (
        .clk_i               (clk),
        .arst_ni             (arst_ni),
        .snk_data_i          (snk_data),
        .snk_startofpacket_i (snk_sop),
        .snk_endofpacket_i   (snk_eop),
        .snk_valid_i         (snk_valid),
        .snk_ready_o         (snk_ready),
        .fifo_data_o         (fifo_data),
        .fifo_wrreq_o        (fifo_wrreq),
        .fifo_usedw_i        (fifo_usedw),
        .pkt_len_o           (pkt_len),
        .pkt_len_valid_o     (pkt_len_valid),
        .pkt_err_o           (pkt_err)
    );

    always @(negedge clk) begin
        if (fifo_wrreq) begin
            wlog[wr_cnt & 63] = fifo_data;
            wr_cnt++;
        end
        if (pkt_len_valid) lv_cnt++;
        if (pkt_len_valid && fifo_wrreq) lvwr_cnt++;
        if (pkt_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic s, input logic e);
        @(negedge clk);
        #1;
        snk_valid = 1'b1;
        snk_data  = d;
        snk_sop   = s;
        snk_eop   = e;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        #1;
        snk_valid = 1'b0;
        snk_sop   = 1'b0;
        snk_eop   = 1'b0;
        repeat (n - 1) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic mark();
        b_wr   = wr_cnt;
        b_lv   = lv_cnt;
        b_err  = err_cnt;
        b_lvwr = lvwr_cnt;
    endtask

    initial begin
        arst_ni    = 1'b0;
        snk_valid  = 1'b0;
        snk_sop    = 1'b0;
        snk_eop    = 1'b0;
        snk_data   = '0;
        fifo_usedw = '0;
        #3;
        chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("rst_data", fifo_data, 32'd0);
        chk("rst_len", 32'(pkt_len), 32'd0);
        chk("rst_lenv", 32'(pkt_len_valid), 32'd0);
        chk("rst_err", 32'(pkt_err), 32'd0);
        chk("rst_ready", 32'(snk_ready), 32'd1);
        chk("rst_state", 32'(dut.state_q), 32'd0);
        @(negedge clk);
        #1 arst_ni = 1'b1;

        // 4-word packet
        mark();
        beat(32'hA0, 1'b1, 1'b0);
        beat(32'hA1, 1'b0, 1'b0);
        beat(32'hA2, 1'b0, 1'b0);
        beat(32'hA3, 1'b0, 1'b1);
        idle(3);
        chk("p4_writes", 32'(wr_cnt - b_wr), 32'd4);
        chk("p4_word0", wlog[b_wr & 63], 32'hA0);
        chk("p4_word3", wlog[(b_wr + 3) & 63], 32'hA3);
        chk("p4_len", 32'(pkt_len), 32'd4);
        chk("p4_lenv", 32'(lv_cnt - b_lv), 32'd1);
        chk("p4_lenv_with_last_wr", 32'(lvwr_cnt - b_lvwr), 32'd1);
        chk("p4_err", 32'(err_cnt - b_err), 32'd0);

        // single-beat packet
        mark();
        beat(32'hB1, 1'b1, 1'b1);
        idle(3);
        chk("p1_writes", 32'(wr_cnt - b_wr), 32'd1);
        chk("p1_word", wlog[b_wr & 63], 32'hB1);
        chk("p1_len", 32'(pkt_len), 32'd1);
        chk("p1_lenv", 32'(lv_cnt - b_lv), 32'd1);
        chk("p1_state", 32'(dut.state_q), 32'd0);

        // backpressure with a write in flight
        mark();
        beat(32'hB0, 1'b1, 1'b0);
        fifo_usedw = 5'd14;
        #1 chk("bp_ready_14_nowr", 32'(snk_ready), 32'd1);
        beat(32'hC1, 1'b0, 1'b0);
        fifo_usedw = 5'd15;
        #1 chk("bp_ready_15_wr", 32'(snk_ready), 32'd0);
        @(negedge clk);
        #1 fifo_usedw = 5'd16;
        #1 chk("bp_ready_16_nowr", 32'(snk_ready), 32'd0);
        idle(1);
        fifo_usedw = 5'd14;
        #1 chk("bp_ready_14_release", 32'(snk_ready), 32'd1);
        fifo_usedw = 5'd0;
        beat(32'hC2, 1'b0, 1'b1);
        idle(3);
        chk("bp_writes", 32'(wr_cnt - b_wr), 32'd2);
        chk("bp_word1", wlog[(b_wr + 1) & 63], 32'hC2);
        chk("bp_len", 32'(pkt_len), 32'd2);

        // 20-word packet against MAX_PKT_LEN=16; word 18 carries a stray sop
        mark();
        for (int i = 1; i <= 17; i++) beat(32'h100 + 32'(i), i == 1, 1'b0);
        beat(32'h112, 1'b1, 1'b0);
        #1;
        chk("ov_writes_at17", 32'(wr_cnt - b_wr), 32'd16);
        chk("ov_err_at17", 32'(err_cnt - b_err), 32'd1);
        chk("ov_state_drop", 32'(dut.state_q), 32'd2);
        beat(32'h113, 1'b0, 1'b0);
        beat(32'h114, 1'b0, 1'b1);
        idle(3);
        chk("ov_writes", 32'(wr_cnt - b_wr), 32'd16);
        chk("ov_word15", wlog[(b_wr + 15) & 63], 32'h110);
        chk("ov_err", 32'(err_cnt - b_err), 32'd1);
        chk("ov_lenv", 32'(lv_cnt - b_lv), 32'd0);
        chk("ov_state", 32'(dut.state_q), 32'd0);

        // sop at word 3 of an open packet
        mark();
        beat(32'hD1, 1'b1, 1'b0);
        beat(32'hD2, 1'b0, 1'b0);
        beat(32'hD3, 1'b1, 1'b0);
        beat(32'hD4, 1'b0, 1'b0);
        beat(32'hD5, 1'b0, 1'b1);
        idle(3);
        chk("rs_writes", 32'(wr_cnt - b_wr), 32'd5);
        chk("rs_err", 32'(err_cnt - b_err), 32'd1);
        chk("rs_lenv", 32'(lv_cnt - b_lv), 32'd1);
        chk("rs_len", 32'(pkt_len), 32'd3);

        // reset mid-packet
        mark();
        beat(32'hE1, 1'b1, 1'b0);
        beat(32'hE2, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        snk_valid = 1'b0;
        arst_ni   = 1'b0;
        #1;
        chk("mr_wrreq", 32'(fifo_wrreq), 32'd0);
        chk("mr_data", fifo_data, 32'd0);
        chk("mr_len", 32'(pkt_len), 32'd0);
        chk("mr_lenv", 32'(pkt_len_valid), 32'd0);
        chk("mr_err", 32'(pkt_err), 32'd0);
        chk("mr_state", 32'(dut.state_q), 32'd0);
        chk("mr_ready", 32'(snk_ready), 32'd1);
        @(negedge clk);
        #1 arst_ni = 1'b1;
        beat(32'hF1, 1'b0, 1'b0);
        idle(3);
        chk("mr_writes", 32'(wr_cnt - b_wr), 32'd2);
        chk("mr_post_err", 32'(err_cnt - b_err), 32'd1);
        chk("mr_post_lenv", 32'(lv_cnt - b_lv), 32'd0);
        chk("mr_post_state", 32'(dut.state_q), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
